// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared LCD geometry, shade encoding and capture FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_WIDTH  = 160;
    localparam int LCD_HEIGHT = 144;

    // Shade 0 is the lightest pixel, 3 the darkest.
    typedef enum logic [1:0] {
        SHADE_LIGHTEST = 2'd0,
        SHADE_LIGHT    = 2'd1,
        SHADE_DARK     = 2'd2,
        SHADE_DARKEST  = 2'd3
    } shade_t;

    localparam logic [0:0] ST_WAIT_VSYNC = 1'b0;
    localparam logic [0:0] ST_CAPTURE    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Rising-edge detector on a registered copy of a level input.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_sig,
    output logic o_edge
);

    logic r_q;

    // Resetting high suppresses an edge on a level that is already high.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_sig;
        end
    end

    assign o_edge = i_sig & ~r_q;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_capture
// Purpose  : Captures the PPU pixel stream into a double-buffered framebuffer.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_capture
    import lcd_pkg::*;
#(
    parameter int WIDTH  = LCD_WIDTH,
    parameter int HEIGHT = LCD_HEIGHT,
    parameter int AW     = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    pixel_data,
    input  logic          pixel_latch,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          capture_en,
    input  logic          err_clear,
    output logic [AW:0]   fb_addr,
    output logic [1:0]    fb_data,
    output logic          fb_we,
    output logic          display_bank,
    output logic          frame_done,
    output logic [7:0]    frame_count,
    output logic          line_err,
    output logic          frame_err
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    localparam logic [XW-1:0] c_X_END     = XW'(WIDTH);
    localparam logic [YW-1:0] c_Y_END     = YW'(HEIGHT);
    localparam logic [AW-1:0] c_LINE_STEP = AW'(WIDTH);

    logic          w_hs_edge;
    logic          w_vs_edge;

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [XW-1:0] r_x,         w_x;
    logic [YW-1:0] r_y,         w_y;
    logic [AW-1:0] r_offset,    w_offset;
    logic [AW-1:0] r_line_base, w_line_base;
    logic [AW:0]   r_fb_addr,   w_fb_addr;
    logic [1:0]    r_fb_data,   w_fb_data;
    logic          r_fb_we,     w_fb_we;
    logic          r_display_bank, w_display_bank;
    logic          r_frame_done,   w_frame_done;
    logic [7:0]    r_frame_count,  w_frame_count;
    logic          r_line_err,     w_line_err;
    logic          r_frame_err,    w_frame_err;

    sync_edge_detect #(.RESET_VAL(1'b1)) u_hsync_edge (
        .clock  (clock),
        .reset  (reset),
        .i_sig  (hsync),
        .o_edge (w_hs_edge)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_vsync_edge (
        .clock  (clock),
        .reset  (reset),
        .i_sig  (vsync),
        .o_edge (w_vs_edge)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_WAIT_VSYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_VSYNC: if (w_vs_edge && capture_en)  w_state_next = ST_CAPTURE;
            ST_CAPTURE:    if (w_vs_edge && !capture_en) w_state_next = ST_WAIT_VSYNC;
            default:       w_state_next = ST_WAIT_VSYNC;
        endcase
    end

    // Events apply in pixel -> hsync -> vsync order, each seeing the prior result.
    always_comb begin
        w_x            = r_x;
        w_y            = r_y;
        w_offset       = r_offset;
        w_line_base    = r_line_base;
        w_fb_we        = 1'b0;
        w_fb_addr      = r_fb_addr;
        w_fb_data      = r_fb_data;
        w_display_bank = r_display_bank;
        w_frame_done   = 1'b0;
        w_frame_count  = r_frame_count;
        w_line_err     = r_line_err  & ~err_clear;
        w_frame_err    = r_frame_err & ~err_clear;

        if (r_state == ST_CAPTURE) begin
            if (pixel_latch) begin
                if (r_x == c_X_END) w_line_err  = 1'b1;
                if (r_y == c_Y_END) w_frame_err = 1'b1;
                if (r_x != c_X_END && r_y != c_Y_END) begin
                    w_fb_we   = 1'b1;
                    w_fb_addr = {~r_display_bank, r_offset};
                    w_fb_data = pixel_data;
                    w_offset  = r_offset + AW'(1);
                    w_x       = r_x + XW'(1);
                end
            end

            if (w_hs_edge && w_y != c_Y_END) begin
                if (w_x != c_X_END) w_line_err = 1'b1;
                w_y         = w_y + YW'(1);
                w_x         = '0;
                w_offset    = w_line_base + c_LINE_STEP;
                w_line_base = w_line_base + c_LINE_STEP;
            end

            if (w_vs_edge && capture_en) begin
                if (w_y == c_Y_END) begin
                    w_display_bank = ~r_display_bank;
                    w_frame_done   = 1'b1;
                    w_frame_count  = r_frame_count + 8'd1;
                end else begin
                    w_frame_err = 1'b1;
                end
            end
        end

        if (w_vs_edge) begin
            w_x         = '0;
            w_y         = '0;
            w_offset    = '0;
            w_line_base = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x            <= '0;
            r_y            <= '0;
            r_offset       <= '0;
            r_line_base    <= '0;
            r_fb_we        <= 1'b0;
            r_fb_addr      <= '0;
            r_fb_data      <= '0;
            r_display_bank <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_count  <= '0;
            r_line_err     <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_x            <= w_x;
            r_y            <= w_y;
            r_offset       <= w_offset;
            r_line_base    <= w_line_base;
            r_fb_we        <= w_fb_we;
            r_fb_addr      <= w_fb_addr;
            r_fb_data      <= w_fb_data;
            r_display_bank <= w_display_bank;
            r_frame_done   <= w_frame_done;
            r_frame_count  <= w_frame_count;
            r_line_err     <= w_line_err;
            r_frame_err    <= w_frame_err;
        end
    end

    assign fb_addr      = r_fb_addr;
    assign fb_data      = r_fb_data;
    assign fb_we        = r_fb_we;
    assign display_bank = r_display_bank;
    assign frame_done   = r_frame_done;
    assign frame_count  = r_frame_count;
    assign line_err     = r_line_err;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_frame_capture
// Purpose  : Directed self-checking bench for lcd_frame_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_capture;

    logic        clock;
    logic        reset;
    logic [1:0]  pixel_data;
    logic        pixel_latch;
    logic        hsync;
    logic        vsync;
    logic        capture_en;
    logic        err_clear;
    logic [15:0] fb_addr;
    logic [1:0]  fb_data;
    logic        fb_we;
    logic        display_bank;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        line_err;
    logic        frame_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lcd_frame_capture dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_data   (pixel_data),
        .pixel_latch  (pixel_latch),
        .hsync        (hsync),
        .vsync        (vsync),
        .capture_en   (capture_en),
        .err_clear    (err_clear),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .display_bank (display_bank),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .line_err     (line_err),
        .frame_err    (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One line of npix back-to-back latches; hsync (and optionally vsync) rise on the last one.
    task automatic send_line(input int y, input int npix, input int base, input bit bank,
                             input bit exp_wr, input bit vs_last,
                             inout int nwr, inout int bad,
                             output logic [15:0] first_addr, output logic [15:0] last_addr);
        first_addr = '0;
        last_addr  = '0;
        for (int i = 0; i < npix; i++) begin
            pixel_latch = 1'b1;
            pixel_data  = 2'((i + y) & 3);
            hsync       = (i == npix - 1);
            vsync       = vs_last && (i == npix - 1);
            tick();
            if (fb_we === 1'b1) nwr++;
            if (i == 0) first_addr = fb_addr;
            last_addr = fb_addr;
            if (exp_wr && i < 160) begin
                if (fb_we !== 1'b1 || fb_addr !== {bank, 15'(base + i)} || fb_data !== 2'((i + y) & 3))
                    bad++;
            end else if (fb_we !== 1'b0) begin
                bad++;
            end
        end
        pixel_latch = 1'b0;
        hsync       = 1'b0;
        vsync       = 1'b0;
    endtask

    task automatic test_reset();
        int nwr = 0, bad = 0;
        logic [15:0] fa, la;
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1;
        tick(); tick(); tick();
        total_cnt++;
        if ({fb_addr, fb_data, fb_we, display_bank, frame_done, frame_count, line_err, frame_err} !== 31'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {fb_addr, fb_data, fb_we, display_bank, frame_done, frame_count, line_err, frame_err});
        else pass_cnt++;
        reset = 1'b0;
        tick(); tick(); tick();
        send_line(0, 160, 0, 1'b1, 1'b0, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (nwr !== 0) $display("FAIL vsync_held_through_reset: got %0d writes want 0", nwr);
        else pass_cnt++;
    endtask

    task automatic test_capture_disable();
        int nwr = 0, bad = 0;
        logic [15:0] fa, la;
        capture_en = 1'b0;
        vsync = 1'b1; tick();
        vsync = 1'b0; tick();
        send_line(0, 160, 0, 1'b1, 1'b0, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (nwr !== 0) $display("FAIL capture_disabled_writes: got %0d want 0", nwr);
        else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL capture_disabled_err: got %b want 0", frame_err);
        else pass_cnt++;
        capture_en = 1'b1;
    endtask

    task automatic test_short_frame();
        int nwr = 0, bad = 0;
        logic [15:0] fa, la;
        vsync = 1'b1; tick();
        vsync = 1'b0;
        for (int y = 0; y < 100; y++)
            send_line(y, 160, y * 160, 1'b1, 1'b1, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (nwr !== 16000 || bad !== 0)
            $display("FAIL short_frame_writes: got %0d writes %0d bad want 16000 writes 0 bad", nwr, bad);
        else pass_cnt++;
        vsync = 1'b1; tick();
        vsync = 1'b0;
        total_cnt++;
        if ({frame_err, frame_done, display_bank, frame_count} !== {1'b1, 1'b0, 1'b0, 8'd0})
            $display("FAIL short_frame_flags: got err=%b done=%b bank=%b cnt=%0d want 1 0 0 0",
                     frame_err, frame_done, display_bank, frame_count);
        else pass_cnt++;
        err_clear = 1'b1; tick();
        err_clear = 1'b0;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL frame_err_clear: got %b want 0", frame_err);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        int nwr = 0, bad = 0;
        logic [15:0] fa, la, first0;
        for (int y = 0; y < 144; y++) begin
            send_line(y, 160, y * 160, 1'b1, 1'b1, y == 143, nwr, bad, fa, la);
            if (y == 0) first0 = fa;
        end
        total_cnt++;
        if (nwr !== 23040 || bad !== 0)
            $display("FAIL full_frame_writes: got %0d writes %0d bad want 23040 writes 0 bad", nwr, bad);
        else pass_cnt++;
        total_cnt++;
        if (first0 !== 16'h8000) $display("FAIL full_frame_first_addr: got %h want 8000", first0);
        else pass_cnt++;
        total_cnt++;
        if (la !== 16'hD9FF) $display("FAIL latch_hsync_vsync_addr: got %h want d9ff", la);
        else pass_cnt++;
        total_cnt++;
        if ({frame_done, display_bank, frame_count, line_err, frame_err} !== {1'b1, 1'b1, 8'd1, 1'b0, 1'b0})
            $display("FAIL full_frame_commit: got done=%b bank=%b cnt=%0d lerr=%b ferr=%b want 1 1 1 0 0",
                     frame_done, display_bank, frame_count, line_err, frame_err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL frame_done_single_pulse: got %b want 0", frame_done);
        else pass_cnt++;
    endtask

    task automatic test_line_errors();
        int nwr = 0, bad = 0;
        logic [15:0] fa, la, first6;
        send_line(0, 161, 0, 1'b0, 1'b1, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (nwr !== 160 || bad !== 0)
            $display("FAIL overlong_line_writes: got %0d writes %0d bad want 160 writes 0 bad", nwr, bad);
        else pass_cnt++;
        total_cnt++;
        if (line_err !== 1'b1) $display("FAIL overlong_line_err: got %b want 1", line_err);
        else pass_cnt++;
        err_clear = 1'b1; tick();
        err_clear = 1'b0;
        total_cnt++;
        if (line_err !== 1'b0) $display("FAIL line_err_clear: got %b want 0", line_err);
        else pass_cnt++;
        for (int y = 1; y < 5; y++)
            send_line(y, 160, y * 160, 1'b0, 1'b1, 1'b0, nwr, bad, fa, la);
        send_line(5, 159, 800, 1'b0, 1'b1, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (line_err !== 1'b1) $display("FAIL short_line_err: got %b want 1", line_err);
        else pass_cnt++;
        first6 = '0;
        for (int y = 6; y < 144; y++) begin
            send_line(y, 160, y * 160, 1'b0, 1'b1, y == 143, nwr, bad, fa, la);
            if (y == 6) first6 = fa;
        end
        total_cnt++;
        if (first6 !== 16'd960) $display("FAIL line6_start_offset: got %h want 03c0", first6);
        else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL err_frame_write_data: got %0d bad writes want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if ({frame_done, display_bank, frame_count, line_err, frame_err} !== {1'b1, 1'b0, 8'd2, 1'b1, 1'b0})
            $display("FAIL err_frame_commit: got done=%b bank=%b cnt=%0d lerr=%b ferr=%b want 1 0 2 1 0",
                     frame_done, display_bank, frame_count, line_err, frame_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int nwr = 0, bad = 0;
        logic [15:0] fa, la;
        for (int y = 0; y < 70; y++)
            send_line(y, 160, y * 160, 1'b1, 1'b1, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (nwr !== 11200 || bad !== 0)
            $display("FAIL pre_reset_writes: got %0d writes %0d bad want 11200 writes 0 bad", nwr, bad);
        else pass_cnt++;
        pixel_latch = 1'b1; pixel_data = 2'd3; reset = 1'b1;
        tick();
        reset = 1'b0; pixel_latch = 1'b0;
        total_cnt++;
        if ({fb_addr, fb_data, fb_we, display_bank, frame_done, frame_count, line_err, frame_err} !== 31'd0)
            $display("FAIL midframe_reset_outputs: got %h want 0",
                     {fb_addr, fb_data, fb_we, display_bank, frame_done, frame_count, line_err, frame_err});
        else pass_cnt++;
        nwr = 0; bad = 0;
        send_line(71, 160, 0, 1'b1, 1'b0, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (nwr !== 0) $display("FAIL post_reset_ignored: got %0d writes want 0", nwr);
        else pass_cnt++;
        vsync = 1'b1; tick();
        vsync = 1'b0;
        send_line(0, 160, 0, 1'b1, 1'b1, 1'b0, nwr, bad, fa, la);
        total_cnt++;
        if (nwr !== 160 || bad !== 0 || fa !== 16'h8000)
            $display("FAIL resume_after_vsync: got %0d writes %0d bad first %h want 160 0 8000", nwr, bad, fa);
        else pass_cnt++;
    endtask

    initial begin
        reset       = 1'b1;
        pixel_data  = 2'd0;
        pixel_latch = 1'b0;
        hsync       = 1'b1;
        vsync       = 1'b1;
        capture_en  = 1'b1;
        err_clear   = 1'b0;
        test_reset();
        test_capture_disable();
        test_short_frame();
        test_full_frame();
        test_line_errors();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_frame_capture.md
# lcd_frame_capture

Receiving end of the PPU's LCD output stream (`pixel_data`, `pixel_latch`, `hsync`, `vsync`). It counts pixels and lines, writes each 2-bit pixel into a double-buffered 160x144 framebuffer, and swaps buffers on every complete frame. The display/scaler side always reads a stable finished frame. It also flags malformed lines and frames.

## Interface
Parameters:
- `WIDTH`, default 160: pixels per line.
- `HEIGHT`, default 144: lines per frame.
- `AW`, default 15: per-bank framebuffer address width. Requires WIDTH*HEIGHT ≤ 2^AW.

Ports:
- `clock` in, 1: system clock; same clock as the PPU.
- `reset` in, 1: synchronous, active-high.
- `pixel_data` in, 2: shade of the current pixel; valid when `pixel_latch`=1.
- `pixel_latch` in, 1: one-cycle strobe per pixel.
- `hsync` in, 1: level; rising edge = end of line.
- `vsync` in, 1: level; rising edge = end of frame / start of next frame.
- `capture_en` in, 1: when 0, the block does not leave WAIT_VSYNC.
- `err_clear` in, 1: clears the sticky error flags.
- `fb_addr` out, AW+1: write address, formed as {write bank, offset}.
- `fb_data` out, 2: write data.
- `fb_we` out, 1: write strobe, one cycle per accepted pixel.
- `display_bank` out, 1: bank holding the last complete frame. The write bank is always `~display_bank`.
- `frame_done` out, 1: one-cycle pulse when a complete frame is committed.
- `frame_count` out, 8: number of complete frames; wraps 255→0.
- `line_err` out, 1: sticky; a line had the wrong pixel count.
- `frame_err` out, 1: sticky; a frame had the wrong line count.

## Operation
- Edge detection:
  - `hsync_q` and `vsync_q` are registered copies of the inputs.
  - hs_edge = hsync & ~hsync_q; vs_edge = vsync & ~vsync_q.
  - On reset, `hsync_q` and `vsync_q` load 1, so a sync input already high at reset produces no edge.
- FSM states:
  - WAIT_VSYNC: entered on reset. Pixels and hs_edge are ignored. vs_edge with `capture_en`=1 → CAPTURE, with x=0, y=0, offset=0.
  - CAPTURE: normal capture. `capture_en`=0 at a vs_edge → WAIT_VSYNC, with no commit and no error.
- Counters: x (0..WIDTH), y (0..HEIGHT), offset (running address, AW bits), line_base (AW bits). No multiplier is used.
- Pixel (CAPTURE, `pixel_latch`):
  - If x<WIDTH and y<HEIGHT: write `pixel_data` at {~display_bank, offset}, then offset+1 and x+1.
  - If x==WIDTH: drop the pixel and set `line_err`.
  - If y==HEIGHT: drop the pixel and set `frame_err`.
- hs_edge (CAPTURE):
  - If y<HEIGHT: if x≠WIDTH, set `line_err`. Then y+1, x=0, line_base+=WIDTH, offset=line_base+WIDTH.
  - If y==HEIGHT: hs_edge is ignored.
- vs_edge (CAPTURE):
  - If y==HEIGHT: commit the frame. Toggle `display_bank`, pulse `frame_done`, increment `frame_count`.
  - Otherwise: set `frame_err`; no swap.
  - In both cases: x=0, y=0, offset=0, line_base=0.
- Same-cycle events are applied in the order pixel → hs_edge → vs_edge, each seeing the previous one's result:
  - A pixel arriving with hs_edge belongs to the ending line.
  - hs_edge arriving with vs_edge on line HEIGHT-1 completes the frame, so the frame commits.
- `err_clear` clears both flags. If the same cycle also sets a flag, the set wins.
- Reset values of the outputs:
  - `fb_addr`=0, `fb_data`=0, `fb_we`=0.
  - `display_bank`=0, `frame_done`=0, `frame_count`=0.
  - `line_err`=0, `frame_err`=0.
  - A reset mid-frame abandons the frame: no commit, no error.

## Timing
- All outputs are registered.
- Input events sampled in cycle N produce their outputs in cycle N+1:
  - `pixel_latch` → `fb_we`, `fb_addr`, `fb_data`.
  - vs_edge → `frame_done`, `display_bank`, `frame_count`.
  - Malformed events → error flags.
- Back-to-back `pixel_latch` (one per cycle) is sustained with no gaps.
- `fb_we` is a single cycle with no handshake; the framebuffer RAM accepts one write per cycle.
- The `display_bank` toggle and the `frame_done` pulse occur in the same cycle.

## Structure
- Shared package `lcd_pkg`:
  - `LCD_WIDTH`=160, `LCD_HEIGHT`=144.
  - Shade encoding (0=lightest, 3=darkest).
  - FSM state encoding {WAIT_VSYNC, CAPTURE}.
- One natural sub-module, `sync_edge_detect`: a registered rising-edge detector with a configurable reset value, instantiated twice (hsync, vsync).
- Counters, FSM, and bank logic are flat in the top module.

## Test plan
- Full frame: vsync, then 144 lines × 160 latches (pixel value = (x+y)&3), each line followed by hsync, then vsync.
  - 23040 `fb_we` with addresses 0x8000..0xD9FF (bank 1).
  - `frame_done` pulses once; `display_bank`=1; `frame_count`=1; no errors.
- Short line: 159 latches then hsync on line 5.
  - `line_err`=1.
  - Line 6 starts at offset 960.
  - Frame still commits.
- Overlong line: 161 latches on line 0.
  - 160 writes; 161st dropped; `line_err`=1.
  - `err_clear` → `line_err`=0.
- Short frame: vsync after 100 lines.
  - `frame_err`=1; no `frame_done`; `display_bank` unchanged.
  - Next full frame commits.
- Simultaneous events:
  - Latch+hsync in the same cycle at x=159: pixel written at offset y*160+159.
  - hsync+vsync in the same cycle on line 143: frame commits.
- Reset/enable:
  - Reset at line 70: all outputs 0; later pixels ignored until vsync.
  - `capture_en`=0 at vsync: stays in WAIT_VSYNC; no writes.
  - `vsync` held high through reset: no edge is detected.
